// File: rtl/noc_out_port_arbiter.sv
// Wormhole round-robin arbiter for one NoC output port: locks a granted input
// from head to tail flit, honours back-pressure, and runs a stalled-packet watchdog.
module noc_out_port_arbiter #(
  parameter int N_IN    = 6,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req_in,
  input  logic [N_IN-1:0]  tail_in,
  input  logic [N_IN-1:0]  en_mask,
  input  logic             busy_in,
  output logic [N_IN-1:0]  select,
  output logic [N_IN-1:0]  grant,
  output logic             valid_out,
  output logic             locked,
  output logic             stall_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_SET   = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_IN - 1);
  localparam logic [N_IN-1:0]  ONE      = N_IN'(1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] win_idx, cur_idx;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;
  logic             win_found;
  logic             transfer;
  logic             stalled;
  logic [N_IN-1:0]  cand;

  assign cand   = req_in & en_mask;
  assign locked = (state == LOCKED);

  // Scan from the highest index down so the last hit is the candidate closest to rr_ptr.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_p;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_p     = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      idx_p = PTR_W'(idx);
      if (cand[idx_p]) begin
        win_found = 1'b1;
        win_idx   = idx_p;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = pkt_count;
    wd_nxt    = '0;
    err_nxt   = stall_err;
    select    = '0;
    transfer  = 1'b0;
    cur_idx   = (state == LOCKED) ? owner : win_idx;

    if (state == LOCKED) begin
      select   = ONE << owner;
      transfer = req_in[owner] & ~busy_in;
    end else if (win_found) begin
      select   = ONE << win_idx;
      transfer = ~busy_in;
    end

    grant     = transfer ? select : '0;
    valid_out = transfer;

    if (transfer) begin
      if (tail_in[cur_idx]) begin
        state_nxt = IDLE;
        rr_nxt    = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
        cnt_nxt   = pkt_count + 1'b1;
      end else if (state == IDLE) begin
        state_nxt = LOCKED;
        owner_nxt = cur_idx;
      end
    end

    // The error fires once, on the stalled cycle that brings the count to TIMEOUT.
    stalled = (state == LOCKED) & ~transfer;
    if (stalled) wd_nxt = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
    if (stalled && (wd_cnt == WD_SET)) err_nxt = 1'b1;
    else if (err_clr)                  err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      wd_cnt    <= '0;
      pkt_count <= '0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      wd_cnt    <= wd_nxt;
      pkt_count <= cnt_nxt;
      stall_err <= err_nxt;
    end
  end

endmodule
